// File: rtl/sram_arb.sv
// ----------------------------------------------------------------------------
// sram_arb -- slot-based arbiter/sequencer in front of a single SRAM controller
//
// Four requesters share one controller command interface. Every SLOT clocks at
// most one command is issued. Command fields are held stable until the next
// winning slot, because the controller consumes wrdata/bsel several clocks
// after cyc. Read data is handed back to the owning port with a one-clock rdy.
// Port 0 (video fetch) has top priority, but it may win only P0_MAX slots in a
// row while any other port is waiting. Ports 1..3 are served round-robin.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rq[3:0]          per-port request, held high until ack
//   rq_addr[83:0]    port n address    at [21n+20:21n]
//   rq_wrdata[63:0]  port n write data at [16n+15:16n]
//   rq_bsel[7:0]     port n byte sel   at [2n+1:2n]
//   rq_rnw[3:0]      per-port read/~write
//   ack[3:0]         one-hot 1-clk pulse: command captured
//   rdy[3:0]         one-hot 1-clk pulse: rdata valid for that port
//   rdata[15:0]      returned read data
//   cyc, req, addr, wrdata, bsel, rnw   command to the SRAM controller
//   sram_do[15:0]    read data from the SRAM controller
// ----------------------------------------------------------------------------
module sram_arb #(
   parameter int SLOT   = 8,   // clocks per slot, >= 7
   parameter int RD_LAT = 6,   // cyc -> sram_do valid, <= SLOT-2
   parameter int P0_MAX = 3    // max consecutive port-0 wins under contention
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  rq,
   input  logic [83:0] rq_addr,
   input  logic [63:0] rq_wrdata,
   input  logic [7:0]  rq_bsel,
   input  logic [3:0]  rq_rnw,
   output logic [3:0]  ack,
   output logic [3:0]  rdy,
   output logic [15:0] rdata,
   output logic        cyc,
   output logic        req,
   output logic [20:0] addr,
   output logic [15:0] wrdata,
   output logic [1:0]  bsel,
   output logic        rnw,
   input  logic [15:0] sram_do
);

   localparam int CW = $clog2(SLOT);
   localparam int SW = $clog2(P0_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);
   localparam logic [CW-1:0] CNT_RD   = CW'(RD_LAT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(P0_MAX);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          cyc_q, cyc_d, req_q, req_d;
   logic [20:0]   addr_q, addr_d;
   logic [15:0]   wrdata_q, wrdata_d;
   logic [1:0]    bsel_q, bsel_d;
   logic          rnw_q, rnw_d;
   logic [3:0]    ack_q, ack_d, rdy_q, rdy_d;
   logic [15:0]   rdata_q, rdata_d;
   logic [1:0]    rr_last_q, rr_last_d;
   logic [SW-1:0] p0_streak_q, p0_streak_d;
   logic          pend_rd_q, pend_rd_d;
   logic [1:0]    owner_q, owner_d;

   logic          p0_win, rr_found, have_win;
   logic [1:0]    rr_win, win;

   // Arbitration candidates. Port 0 may exceed its streak cap only when
   // nobody else is waiting; the round-robin search starts after rr_last.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      rr_found = 1'b0;
      rr_win   = rr_last_q;
      for (int k = 1; k <= 3; k++) begin
         if (!rr_found && rq[((int'(rr_last_q) - 1 + k) % 3) + 1]) begin
            rr_found = 1'b1;
            rr_win   = 2'(((int'(rr_last_q) - 1 + k) % 3) + 1);
         end
      end
      p0_win = rq[0] && ((p0_streak_q < STREAK_MAX) || !(|rq[3:1]));
   end

   always_comb begin
      cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      cyc_d       = 1'b0;
      req_d       = 1'b0;
      ack_d       = 4'b0000;
      rdy_d       = 4'b0000;
      addr_d      = addr_q;
      wrdata_d    = wrdata_q;
      bsel_d      = bsel_q;
      rnw_d       = rnw_q;
      rdata_d     = rdata_q;
      rr_last_d   = rr_last_q;
      p0_streak_d = p0_streak_q;
      pend_rd_d   = pend_rd_q;
      owner_d     = owner_q;
      have_win    = 1'b0;
      win         = 2'd0;

      // Decide at the last clock of a slot; the registered result is the
      // command for cnt==0 of the next slot.
      if (cnt_q == CNT_LAST) begin
         if (p0_win) begin
            have_win = 1'b1;
            win      = 2'd0;
            if (p0_streak_q != STREAK_MAX)
               p0_streak_d = p0_streak_q + SW'(1);
         end else if (rr_found) begin
            have_win    = 1'b1;
            win         = rr_win;
            rr_last_d   = rr_win;
            p0_streak_d = '0;
         end else begin
            p0_streak_d = '0;
         end

         if (have_win) begin
            cyc_d      = 1'b1;
            req_d      = 1'b1;
            ack_d[win] = 1'b1;
            addr_d     = rq_addr[int'(win) * 21 +: 21];
            wrdata_d   = rq_wrdata[int'(win) * 16 +: 16];
            bsel_d     = rq_bsel[int'(win) * 2 +: 2];
            rnw_d      = rq_rnw[win];
            if (rq_rnw[win]) begin
               pend_rd_d = 1'b1;
               owner_d   = win;
            end
         end
      end

      // sram_do is valid RD_LAT clocks after cyc; capture it for the owner.
      if (cnt_q == CNT_RD && pend_rd_q) begin
         rdata_d        = sram_do;
         rdy_d[owner_q] = 1'b1;
         pend_rd_d      = 1'b0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         wrdata_q    <= '0;
         bsel_q      <= '0;
         rnw_q       <= 1'b1;
         ack_q       <= '0;
         rdy_q       <= '0;
         rdata_q     <= '0;
         rr_last_q   <= 2'd3;
         p0_streak_q <= '0;
         pend_rd_q   <= 1'b0;
         owner_q     <= 2'd0;
      end else begin
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         wrdata_q    <= wrdata_d;
         bsel_q      <= bsel_d;
         rnw_q       <= rnw_d;
         ack_q       <= ack_d;
         rdy_q       <= rdy_d;
         rdata_q     <= rdata_d;
         rr_last_q   <= rr_last_d;
         p0_streak_q <= p0_streak_d;
         pend_rd_q   <= pend_rd_d;
         owner_q     <= owner_d;
      end
   end

   assign cyc    = cyc_q;
   assign req    = req_q;
   assign addr   = addr_q;
   assign wrdata = wrdata_q;
   assign bsel   = bsel_q;
   assign rnw    = rnw_q;
   assign ack    = ack_q;
   assign rdy    = rdy_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_sram_arb.sv
// ----------------------------------------------------------------------------
// tb_sram_arb -- directed bench for sram_arb (SLOT=8, RD_LAT=6, P0_MAX=3).
// A tiny controller model drives sram_do with mem_val exactly RD_LAT clocks
// after each cyc and zero otherwise. Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sram_arb;

   localparam int SLOT   = 8;
   localparam int RD_LAT = 6;
   localparam int P0_MAX = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rq = '0;
   logic [83:0] rq_addr = '0;
   logic [63:0] rq_wrdata = '0;
   logic [7:0]  rq_bsel = '0;
   logic [3:0]  rq_rnw = '0;
   logic [3:0]  ack, rdy;
   logic [15:0] rdata, wrdata, sram_do;
   logic        cyc, req, rnw;
   logic [20:0] addr;
   logic [1:0]  bsel;

   logic [15:0] mem_val = 16'h0000;
   logic [3:0]  lat = 4'd0;

   int checks = 0;
   int failures = 0;

   sram_arb #(.SLOT(SLOT), .RD_LAT(RD_LAT), .P0_MAX(P0_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .rq(rq), .rq_addr(rq_addr),
      .rq_wrdata(rq_wrdata), .rq_bsel(rq_bsel), .rq_rnw(rq_rnw),
      .ack(ack), .rdy(rdy), .rdata(rdata), .cyc(cyc), .req(req),
      .addr(addr), .wrdata(wrdata), .bsel(bsel), .rnw(rnw), .sram_do(sram_do)
   );

   always #5 clk = ~clk;

   // Controller model: lat counts clocks since the last cyc.
   always @(posedge clk) begin
      if (cyc) lat <= 4'd1;
      else if (lat != 4'd0 && lat != 4'd15) lat <= lat + 4'd1;
   end
   assign sram_do = (lat == 4'(RD_LAT)) ? mem_val : 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Step falling edges until cyc is seen; n = edges stepped, rdy_seen = OR of rdy.
   task automatic wait_cyc(input string tag, input int budget, output int n, output logic [3:0] rdy_seen);
      n = 0;
      rdy_seen = '0;
      do begin
         @(negedge clk);
         n++;
         rdy_seen |= rdy;
      end while (!cyc && n < budget);
      if (!cyc) check({tag, "_timeout"}, 32'(n), 32'(budget + 1));
   endtask

   logic [3:0] any_ack, any_rdy, rs;
   logic       any_cyc, stable_ok;
   int         n;
   logic [3:0] exp_seq [12] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h4,
                                4'h1, 4'h1, 4'h1, 4'h8};
   logic [3:0] exp_rr [3] = '{4'h2, 4'h8, 4'h2};

   initial begin
      // ---- reset state and idle slots ----
      repeat (2) @(negedge clk);
      check("rst_cyc", 32'(cyc), 32'd0);
      check("rst_rnw", 32'(rnw), 32'd1);
      check("rst_bsel", 32'(bsel), 32'd0);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      rst_n = 1'b1;
      any_cyc = 1'b0; any_ack = '0; any_rdy = '0;
      repeat (3 * SLOT) begin
         @(negedge clk);
         any_cyc |= cyc; any_ack |= ack; any_rdy |= rdy;
      end
      check("idle_cyc", 32'(any_cyc), 32'd0);
      check("idle_ack", 32'(any_ack), 32'd0);
      check("idle_rdy", 32'(any_rdy), 32'd0);
      check("idle_rnw", 32'(rnw), 32'd1);
      check("idle_bsel", 32'(bsel), 32'd0);

      // ---- port 1 read ----
      rq_addr[41:21] = 21'h12345;
      rq_rnw[1] = 1'b1;
      mem_val = 16'hBEEF;
      rq[1] = 1'b1;
      wait_cyc("p1rd", 20, n, rs);
      check("p1rd_req", 32'(req), 32'd1);
      check("p1rd_addr", 32'(addr), 32'h12345);
      check("p1rd_ack", 32'(ack), 32'h2);
      check("p1rd_rnw", 32'(rnw), 32'd1);
      rq[1] = 1'b0;
      any_rdy = '0;
      repeat (RD_LAT) begin
         @(negedge clk);
         any_rdy |= rdy;
      end
      check("p1rd_early_rdy", 32'(any_rdy), 32'd0);
      @(negedge clk);
      check("p1rd_rdy", 32'(rdy), 32'h2);
      check("p1rd_rdata", 32'(rdata), 32'hBEEF);
      @(negedge clk);
      check("p1rd_rdy_pulse", 32'(rdy), 32'd0);

      // ---- port 2 write ----
      rq_addr[62:42] = 21'h00010;
      rq_wrdata[47:32] = 16'hA55A;
      rq_bsel[5:4] = 2'b01;
      rq_rnw[2] = 1'b0;
      rq[2] = 1'b1;
      wait_cyc("p2wr", 20, n, rs);
      check("p2wr_ack", 32'(ack), 32'h4);
      check("p2wr_rnw", 32'(rnw), 32'd0);
      check("p2wr_addr", 32'(addr), 32'h10);
      rq[2] = 1'b0;
      rq_wrdata[47:32] = 16'h0000;   // requester free to change after ack
      rq_bsel[5:4] = 2'b10;
      stable_ok = (wrdata === 16'hA55A) && (bsel === 2'b01);
      any_rdy = rdy;
      @(negedge clk);
      check("p2wr_cyc_pulse", 32'(cyc), 32'd0);
      stable_ok &= (wrdata === 16'hA55A) && (bsel === 2'b01);
      any_rdy |= rdy;
      repeat (SLOT - 2) begin
         @(negedge clk);
         stable_ok &= (wrdata === 16'hA55A) && (bsel === 2'b01);
         any_rdy |= rdy;
      end
      check("p2wr_stable", 32'(stable_ok), 32'd1);
      check("p2wr_no_rdy", 32'(any_rdy), 32'd0);

      // ---- reset in the middle of a port 3 read ----
      rq_addr[83:63] = 21'h1ABCD;
      rq_rnw[3] = 1'b1;
      mem_val = 16'h1234;
      rq[3] = 1'b1;
      wait_cyc("p3rd", 20, n, rs);
      check("p3rd_ack", 32'(ack), 32'h8);
      any_rdy = '0;
      repeat (3) begin
         @(negedge clk);
         any_rdy |= rdy;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_addr", 32'(addr), 32'd0);
      check("mid_rst_rnw", 32'(rnw), 32'd1);
      repeat (2) begin
         @(negedge clk);
         any_rdy |= rdy;
      end
      rst_n = 1'b1;           // rq[3] still high: re-request
      wait_cyc("p3re", 20, n, rs);
      any_rdy |= rs;
      check("mid_rst_no_rdy", 32'(any_rdy), 32'd0);
      check("mid_rst_first_cyc", 32'(n), 32'(SLOT));
      check("p3re_ack", 32'(ack), 32'h8);
      check("p3re_addr", 32'(addr), 32'h1ABCD);
      rq[3] = 1'b0;
      repeat (RD_LAT + 1) @(negedge clk);
      check("p3re_rdy", 32'(rdy), 32'h8);
      check("p3re_rdata", 32'(rdata), 32'h1234);

      // ---- all ports requesting continuously ----
      rq_rnw = 4'hF;
      rq = 4'hF;
      for (int s = 0; s < 12; s++) begin
         wait_cyc("all", 20, n, rs);
         check($sformatf("all_ack_slot%0d", s), 32'(ack), 32'(exp_seq[s]));
      end

      // ---- ports 1 and 3 only ----
      rq = 4'b1010;
      for (int s = 0; s < 3; s++) begin
         wait_cyc("rr", 20, n, rs);
         check($sformatf("rr_ack_slot%0d", s), 32'(ack), 32'(exp_rr[s]));
      end
      rq = 4'b0000;
      repeat (2 * SLOT) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
